// File: rtl/mux_arb_n.sv
// N-channel select/arbitrate mux feeding one registered valid/ready output stage.
// Direct mode picks the channel named by select; round-robin mode scans from rr_ptr.
module mux_arb_n #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 32,
  parameter int unsigned SEL_BITS = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_BITS-1:0]       select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_BITS:0]   CH_EXT  = (SEL_BITS+1)'(CHANNELS);
  localparam logic [SEL_BITS-1:0] LAST_CH = SEL_BITS'(CHANNELS - 1);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_BITS-1:0] out_channel_q, out_channel_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;

  logic                load_c;
  logic                xfer_c;
  logic                gnt_found_c;
  logic [SEL_BITS-1:0] gnt_idx_c;
  logic [WIDTH-1:0]    gnt_data_c;
  logic [SEL_BITS:0]   best_dist_c;
  logic [SEL_BITS:0]   dist_c;
  logic [SEL_BITS:0]   idx_ext_c;
  logic [SEL_BITS:0]   ptr_ext_c;

  assign load_c = !out_valid_q || out_ready;
  assign xfer_c = !reset && load_c && gnt_found_c;

  // Grant selection; round-robin picks the valid channel nearest rr_ptr in wrap order.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    best_dist_c = CH_EXT;
    dist_c      = '0;
    idx_ext_c   = '0;
    ptr_ext_c   = {1'b0, rr_ptr_q};
    if (!mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if ((SEL_BITS'(i) == select) && in_valid[i]) begin
          gnt_found_c = 1'b1;
          gnt_idx_c   = SEL_BITS'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        idx_ext_c = (SEL_BITS+1)'(i);
        dist_c    = (idx_ext_c >= ptr_ext_c) ? (idx_ext_c - ptr_ext_c)
                                             : (idx_ext_c + CH_EXT - ptr_ext_c);
        if (in_valid[i] && (dist_c < best_dist_c)) begin
          best_dist_c = dist_c;
          gnt_found_c = 1'b1;
          gnt_idx_c   = SEL_BITS'(i);
        end
      end
    end
  end

  // Data mux and one-hot accept for the granted channel.
  always_comb begin
    gnt_data_c = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (SEL_BITS'(i) == gnt_idx_c) begin
        gnt_data_c  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = xfer_c;
      end
    end
  end

  // Next-state for the output stage and arbitration pointer.
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    rr_ptr_d      = rr_ptr_q;
    if (xfer_c) begin
      out_data_d    = gnt_data_c;
      out_channel_d = gnt_idx_c;
      out_valid_d   = 1'b1;
      if (mode) begin
        rr_ptr_d = (gnt_idx_c == LAST_CH) ? '0 : gnt_idx_c + SEL_BITS'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: a 32-channel instance plus a 24-channel one
// sharing the same stimulus for the out-of-range select case.
module tb_mux_arb_n;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CH    = 32;
  localparam int unsigned CH24  = 24;

  typedef struct packed {
    logic [4:0]  ch;
    logic [31:0] data;
  } exp_t;

  logic              clock;
  logic              reset;
  logic              mode;
  logic [4:0]        select;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [4:0]        out_channel;
  logic              out_valid;
  logic              out_ready;

  logic [CH24-1:0]   in_ready24;
  logic [WIDTH-1:0]  out_data24;
  logic [4:0]        out_channel24;
  logic              out_valid24;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp;
  int   n_err;

  mux_arb_n #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_BITS(5)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .select      (select),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  mux_arb_n #(.WIDTH(WIDTH), .CHANNELS(CH24), .SEL_BITS(5)) u_dut24 (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .select      (select),
    .in_data     (in_data[CH24*WIDTH-1:0]),
    .in_valid    (in_valid[CH24-1:0]),
    .in_ready    (in_ready24),
    .out_data    (out_data24),
    .out_channel (out_channel24),
    .out_valid   (out_valid24),
    .out_ready   (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_ch(input int ch, input logic [31:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b1; select = '0; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < int'(CH); i++) set_ch(i, 32'h1000 + 32'(i));
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (in_ready !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_channel !== '0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got rdy=%h v=%b d=%h ch=%0d, want rdy=0 v=0 d=0 ch=0",
                 c, in_ready, out_valid, out_data, out_channel);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 32'h1) begin
      n_err++;
      $display("FAIL reset_first_grant: got in_ready=%h, want 00000001", in_ready);
    end
    exp_q.push_back('{ch: 5'd0, data: 32'h1000});
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
      n_err++;
      $display("FAIL reset_first_out: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
               out_valid, out_channel, out_data, e.ch, e.data);
    end
    in_valid = '0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_direct();
    mode = 1'b0; select = 5'd5; out_ready = 1'b1;
    set_ch(5, 32'hDEADBEEF);
    in_valid = 32'h20;
    #1;
    n_cmp++;
    if (in_ready !== 32'h20) begin
      n_err++;
      $display("FAIL direct_ready: got in_ready=%h, want 00000020", in_ready);
    end
    exp_q.push_back('{ch: 5'd5, data: 32'hDEADBEEF});
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
      n_err++;
      $display("FAIL direct_out: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
               out_valid, out_channel, out_data, e.ch, e.data);
    end
    select = 5'd31;
    set_ch(31, 32'h3131_3131);
    in_valid = 32'h80FF_FFFF;
    #1;
    n_cmp++;
    if (in_ready24 !== '0) begin
      n_err++;
      $display("FAIL direct_oor_ready: got in_ready24=%h, want 000000", in_ready24);
    end
    n_cmp++;
    if (in_ready !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL direct_sel31_ready: got in_ready=%h, want 80000000", in_ready);
    end
    exp_q.push_back('{ch: 5'd31, data: 32'h3131_3131});
    step();
    n_cmp++;
    if (out_valid24 !== 1'b0 || $isunknown({out_data24, out_channel24})) begin
      n_err++;
      $display("FAIL direct_oor_out: got v24=%b d24=%h ch24=%0d, want v24=0 and no X",
               out_valid24, out_data24, out_channel24);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
      n_err++;
      $display("FAIL direct_sel31_out: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
               out_valid, out_channel, out_data, e.ch, e.data);
    end
    in_valid = '0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL direct_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  // Pointer sits at 1 on entry, so the scan order from it is 3, 7, 30.
  task automatic test_round_robin();
    int exp_ch [6] = '{3, 7, 30, 3, 7, 30};
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < int'(CH); i++) set_ch(i, 32'hA000_0000 + 32'(i));
    in_valid = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 30);
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== (32'h1 << exp_ch[k])) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: got in_ready=%h, want channel %0d", k, in_ready, exp_ch[k]);
      end
      exp_q.push_back('{ch: 5'(exp_ch[k]), data: 32'hA000_0000 + 32'(exp_ch[k])});
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
        n_err++;
        $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
                 k, out_valid, out_channel, out_data, e.ch, e.data);
      end
    end
    in_valid = '0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rr_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  // Last grant went to 30, so the pointer is 31.
  task automatic test_wrap();
    int exp_ch [2] = '{31, 0};
    mode = 1'b1; out_ready = 1'b1;
    in_valid = 32'h8000_0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== (32'h1 << exp_ch[k])) begin
        n_err++;
        $display("FAIL wrap_ready[%0d]: got in_ready=%h, want channel %0d", k, in_ready, exp_ch[k]);
      end
      exp_q.push_back('{ch: 5'(exp_ch[k]), data: 32'hA000_0000 + 32'(exp_ch[k])});
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
        n_err++;
        $display("FAIL wrap_out[%0d]: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
                 k, out_valid, out_channel, out_data, e.ch, e.data);
      end
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    mode = 1'b0; select = 5'd9; out_ready = 1'b0;
    set_ch(9, 32'h11);
    set_ch(2, 32'h22);
    in_valid = 32'h1 << 9;
    #1;
    n_cmp++;
    if (in_ready !== (32'h1 << 9)) begin
      n_err++;
      $display("FAIL bp_first_ready: got in_ready=%h, want 00000200", in_ready);
    end
    exp_q.push_back('{ch: 5'd9, data: 32'h11});
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
      n_err++;
      $display("FAIL bp_first_out: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
               out_valid, out_channel, out_data, e.ch, e.data);
    end
    select = 5'd2;
    in_valid = 32'h1 << 2;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== '0) begin
        n_err++;
        $display("FAIL bp_stall_ready[%0d]: got in_ready=%h, want 0", c, in_ready);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h11 || out_channel !== 5'd9) begin
        n_err++;
        $display("FAIL bp_stall_hold[%0d]: got v=%b d=%h ch=%0d, want v=1 d=00000011 ch=9",
                 c, out_valid, out_data, out_channel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 32'h4) begin
      n_err++;
      $display("FAIL bp_release_ready: got in_ready=%h, want 00000004", in_ready);
    end
    exp_q.push_back('{ch: 5'd2, data: 32'h22});
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
      n_err++;
      $display("FAIL bp_release_out: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
               out_valid, out_channel, out_data, e.ch, e.data);
    end
    in_valid = '0;
    step();
  endtask

  // Pointer is 1 on entry; a grant to 8 moves it to 9 before reset hits.
  task automatic test_reset_mid();
    mode = 1'b1; out_ready = 1'b0;
    set_ch(8, 32'h0808_0808);
    set_ch(0, 32'hC0C0_0000);
    in_valid = 32'h1 << 8;
    #1;
    n_cmp++;
    if (in_ready !== (32'h1 << 8)) begin
      n_err++;
      $display("FAIL rmid_ready: got in_ready=%h, want 00000100", in_ready);
    end
    exp_q.push_back('{ch: 5'd8, data: 32'h0808_0808});
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
      n_err++;
      $display("FAIL rmid_out: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
               out_valid, out_channel, out_data, e.ch, e.data);
    end
    reset = 1'b1;
    in_valid = '1;
    #1;
    n_cmp++;
    if (in_ready !== '0) begin
      n_err++;
      $display("FAIL rmid_reset_ready: got in_ready=%h, want 0", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL rmid_reset_out: got v=%b d=%h, want v=0 d=0", out_valid, out_data);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = (32'h1 << 0) | (32'h1 << 10);
    #1;
    n_cmp++;
    if (in_ready !== 32'h1) begin
      n_err++;
      $display("FAIL rmid_after_ready: got in_ready=%h, want 00000001", in_ready);
    end
    exp_q.push_back('{ch: 5'd0, data: 32'hC0C0_0000});
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
      n_err++;
      $display("FAIL rmid_after_out: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
               out_valid, out_channel, out_data, e.ch, e.data);
    end
    in_valid = '0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; mode = 1'b0; select = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    test_reset();
    test_direct();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised successor to the processor's fixed-width select muxes.
- Selects one of CHANNELS input words of WIDTH bits and registers it into a single output stage with a valid/ready handshake.
- Two modes: direct (explicit select index) and round-robin arbitration across requesting channels.
- Used wherever several producers share one downstream consumer, e.g. writeback or memory-request funnels.

Parameters:
WIDTH, 32, data width of each channel in bits
CHANNELS, 32, number of input channels (2..32)
SEL_BITS, 5, width of select and out_channel; must satisfy 2^SEL_BITS >= CHANNELS

Ports:
clock  input  1  single system clock, rising-edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = direct select, 1 = round-robin arbitration
select  input  SEL_BITS  channel index used in direct mode
in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel request
in_ready  output  CHANNELS  per-channel accept; one-hot or zero
out_data  output  WIDTH  registered selected word
out_channel  output  SEL_BITS  index of the channel that produced out_data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts when high with out_valid

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high, sampled on the rising clock edge.
- Reset values: out_valid=0, out_data=0, out_channel=0, round-robin pointer rr_ptr=0. in_ready is all-zero while reset is high.
- Load enable, combinational: load = !out_valid || out_ready.
- Grant, combinational, direct mode (mode=0):
  - grant = select when select < CHANNELS and in_valid[select]=1; otherwise no grant.
  - Out-of-range select never grants and never causes X on outputs.
- Grant, round-robin mode (mode=1):
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., CHANNELS-1, 0, ..., rr_ptr-1 (wrap-around).
  - No valid bit set means no grant.
- in_ready[g] = load && grant exists && g==grant. All other in_ready bits are 0.
- Transfer on input side: in_valid[g] && in_ready[g] at a rising edge.
- Register update at each rising edge, when not in reset:
  - Input transfer: out_data <= in_data[g], out_channel <= g, out_valid <= 1.
  - Else, if out_valid && out_ready: out_valid <= 0. out_data and out_channel hold their last values.
  - Else: all output registers hold.
- Simultaneous output consume and new grant in the same cycle: the new word replaces the old one and out_valid stays 1, giving full throughput of one word per cycle.
- Latency: exactly 1 cycle from input transfer to out_valid=1.
- Backpressure: while out_valid=1 && out_ready=0, no in_ready is asserted and out_data/out_channel are stable.
- rr_ptr updates only on an input transfer in mode 1: rr_ptr <= (g==CHANNELS-1) ? 0 : g+1. It holds in mode 0 and on cycles with no transfer.
- Mode change: takes effect on the next grant evaluation and does not disturb a held output word.
- Reset mid-operation: a pending output word is discarded and in_ready drops in the same cycle reset is high. The pointer returns to 0.
- No combinational path from out_ready to out_data. The out_ready -> in_ready path is permitted.

Test Plan:
- Reset, then idle: hold reset high for 2 cycles with in_valid=all ones -> out_valid=0, out_data=0, in_ready=0. After release, with mode=1 and out_ready=1, the first grant is channel 0.
- Direct mode: mode=0, select=5, in_data ch5=0xDEADBEEF, in_valid[5]=1, out_ready=1 -> in_ready=0x20 that cycle. Next cycle out_valid=1, out_data=0xDEADBEEF, out_channel=5. Then select=31 with CHANNELS=24 -> in_ready=0 and out_valid falls to 0.
- Round-robin fairness: mode=1, in_valid[3], in_valid[7] and in_valid[30] held high, out_ready=1 -> grants cycle 3, 7, 30, 3, 7, ... with one word per cycle. out_channel follows the same order one cycle later.
- Backpressure: out_valid=1 with data 0x11, out_ready=0 for 4 cycles while ch2 is valid -> out_data stays 0x11 and in_ready stays 0. When out_ready=1, ch2's word loads in that same edge and out_valid remains 1.
- Wrap-around: CHANNELS=32, rr_ptr at 31 (after a grant to 30), in_valid = bit 31 and bit 0 -> grant 31, then rr_ptr=0 and the next grant is 0.
- Reset mid-stream: assert reset while out_valid=1 and rr_ptr=9 -> next edge gives out_valid=0, and after release the first round-robin grant scans from 0.
